// File: rtl/mac_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mac_ctrl_pkg : shared FSM encoding and MAC datapath constants for mac_ctrl
// Revision     : 1.0
// ============================================================================
package mac_ctrl_pkg;

    localparam int MAC_W = 20;
    localparam int LANES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_ctrl.sv
`default_nettype none
// ============================================================================
// mac_ctrl : buffer-read sequencer and dot-product accumulator for one MAC job
//            (optional MAC_CTRL_RELU_EN clamps negative results to zero)
// Revision : 1.0
// ============================================================================
module mac_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_nchunk,
    output logic              busy,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              mac_vld,
    input  logic [MAC_W-1:0]  mac_acc,
    input  logic              mac_acc_vld,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_vld,
    input  logic              res_rdy,
    output logic              done
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDR_W-1:0]        r_addr;
    logic [ADDR_W-1:0]        r_nchunk;
    logic [ADDR_W-1:0]        r_iss_cnt;
    logic [ADDR_W-1:0]        r_rcv_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_acc_ext;
    logic                     r_mac_vld;
    logic                     r_done;
    logic                     w_start_acc;
    logic                     w_acc_en;
    logic                     w_last_iss;
    logic                     w_last_rcv;

    assign w_acc_ext  = ACC_W'($signed(mac_acc));
    assign w_last_iss = (r_iss_cnt == (r_nchunk - ADDR_W'(1)));
    // Completion is decided purely by counting returns; MAC latency is unknown.
    assign w_last_rcv = mac_acc_vld && ((r_rcv_cnt + ADDR_W'(1)) == r_nchunk);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_acc_en    = 1'b0;
        busy        = 1'b1;
        buf_rd_en   = 1'b0;
        res_vld     = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = (cfg_nchunk == '0) ? OUT : ISSUE;
                end
            end
            ISSUE: begin
                buf_rd_en = 1'b1;
                w_acc_en  = mac_acc_vld;
                if (w_last_rcv) begin
                    w_state_nxt = OUT;
                end else if (w_last_iss) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_acc_en = mac_acc_vld;
                if (w_last_rcv) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                res_vld = 1'b1;
                if (res_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr    <= '0;
            r_nchunk  <= '0;
            r_iss_cnt <= '0;
            r_rcv_cnt <= '0;
            r_acc     <= '0;
            r_mac_vld <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_mac_vld <= buf_rd_en;
            r_done    <= res_vld && res_rdy;
            if (w_start_acc) begin
                r_addr    <= cfg_base;
                r_nchunk  <= cfg_nchunk;
                r_iss_cnt <= '0;
                r_rcv_cnt <= '0;
                r_acc     <= '0;
            end else begin
                if (buf_rd_en) begin
                    r_addr    <= r_addr + ADDR_W'(1);
                    r_iss_cnt <= r_iss_cnt + ADDR_W'(1);
                end
                if (w_acc_en) begin
                    r_acc     <= r_acc + w_acc_ext;
                    r_rcv_cnt <= r_rcv_cnt + ADDR_W'(1);
                end
            end
        end
    end

    assign buf_addr = r_addr;
    assign mac_vld  = r_mac_vld;
    assign done     = r_done;

`ifdef MAC_CTRL_RELU_EN
    assign res_data = r_acc[ACC_W-1] ? '0 : r_acc;
`else
    assign res_data = r_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mac_ctrl : scoreboard bench for mac_ctrl with a randomized-latency MAC model
// Revision    : 1.0
// ============================================================================
module tb_mac_ctrl;

    localparam int ADDR_W = 10;
    localparam int ACC_W  = 32;
    localparam int MAC_W  = 20;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [ADDR_W-1:0] cfg_nchunk = '0;
    logic              busy;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_addr;
    logic              mac_vld;
    logic [MAC_W-1:0]  mac_acc = '0;
    logic              mac_acc_vld = 1'b0;
    logic [ACC_W-1:0]  res_data;
    logic              res_vld;
    logic              res_rdy = 1'b1;
    logic              done;

    always #5 clk = ~clk;

    mac_ctrl #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_base(cfg_base),
        .cfg_nchunk(cfg_nchunk), .busy(busy), .buf_rd_en(buf_rd_en),
        .buf_addr(buf_addr), .mac_vld(mac_vld), .mac_acc(mac_acc),
        .mac_acc_vld(mac_acc_vld), .res_data(res_data), .res_vld(res_vld),
        .res_rdy(res_rdy), .done(done)
    );

    int                n_cmp = 0;
    int                n_bad = 0;
    int unsigned       cyc = 0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [ACC_W-1:0]  exp_res_q[$];
    int                mac_src_q[$];
    int                pend_val_q[$];
    int unsigned       pend_due_q[$];
    logic              exp_done = 1'b0;
    logic              prev_rd_en = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endfunction

    // Reference: the result is the plain integer sum, wrapped to ACC_W bits.
    function automatic logic [ACC_W-1:0] model(input int vals[$]);
        longint           s = 0;
        logic [ACC_W-1:0] r;
        foreach (vals[i]) s += vals[i];
        r = s[ACC_W-1:0];
`ifdef MAC_CTRL_RELU_EN
        if ($signed(r) < 0) r = '0;
`endif
        return r;
    endfunction

    function automatic int rnd_val();
        return int'($urandom_range(0, 1048575)) - 524288;
    endfunction

    function automatic void chk_zero_outputs(input string tag);
        chk({tag, "_busy"},   64'(busy),      64'd0);
        chk({tag, "_rd_en"},  64'(buf_rd_en), 64'd0);
        chk({tag, "_macvld"}, 64'(mac_vld),   64'd0);
        chk({tag, "_resvld"}, 64'(res_vld),   64'd0);
        chk({tag, "_done"},   64'(done),      64'd0);
        chk({tag, "_addr"},   64'(buf_addr),  64'd0);
        chk({tag, "_data"},   64'(res_data),  64'd0);
    endfunction

    // MAC model: returns operands in order after a random extra latency.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                pend_val_q.delete();
                pend_due_q.delete();
                mac_acc_vld = 1'b0;
            end else if (pend_val_q.size() > 0 && pend_due_q[0] <= cyc) begin
                mac_acc_vld = 1'b1;
                mac_acc     = MAC_W'(pend_val_q.pop_front());
                void'(pend_due_q.pop_front());
            end else begin
                mac_acc_vld = 1'b0;
                mac_acc     = MAC_W'($urandom);
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                prev_rd_en = 1'b0;
                exp_done   = 1'b0;
            end else begin
                if (mac_vld || prev_rd_en) chk("mac_vld_delay", 64'(mac_vld), 64'(prev_rd_en));
                prev_rd_en = buf_rd_en;
                if (mac_vld) begin
                    if (mac_src_q.size() == 0) begin
                        chk("mac_vld_extra", 64'(mac_vld), 64'd0);
                    end else begin
                        pend_val_q.push_back(mac_src_q.pop_front());
                        pend_due_q.push_back(cyc + $urandom_range(0, 4));
                    end
                end
                if (buf_rd_en) begin
                    if (exp_addr_q.size() == 0) chk("rd_en_extra", 64'(buf_rd_en), 64'd0);
                    else chk("buf_addr", 64'(buf_addr), 64'(exp_addr_q.pop_front()));
                end
                if (done || exp_done) chk("done_pulse", 64'(done), 64'(exp_done));
                exp_done = res_vld && res_rdy;
                if (res_vld && res_rdy) begin
                    if (exp_res_q.size() == 0) chk("res_extra", 64'(res_vld), 64'd0);
                    else chk("res_data", 64'(res_data), 64'(exp_res_q.pop_front()));
                end
            end
        end
    end

    task automatic run_job(input logic [ADDR_W-1:0] base, input int n, input int vals[$],
                           input int hold, input bit poke);
        logic [ACC_W-1:0] held;
        bit               seen;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        if (busy) fail("idle_wait");
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) exp_addr_q.push_back(ADDR_W'(base + ADDR_W'(i)));
        foreach (vals[i]) mac_src_q.push_back(vals[i]);
        exp_res_q.push_back(model(vals));
        cfg_base   = base;
        cfg_nchunk = ADDR_W'(n);
        start      = 1'b1;
        if (hold > 0) res_rdy = 1'b0;
        @(posedge clk);
        #1;
        start      = 1'b0;
        cfg_base   = ADDR_W'($urandom);
        cfg_nchunk = ADDR_W'($urandom);
        if (hold > 0) begin
            seen = 1'b0;
            for (int i = 0; i < 400 && !seen; i++) begin
                @(negedge clk);
                seen = res_vld;
            end
            if (!seen) fail("res_vld_wait");
            held = res_data;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_vld",  64'(res_vld),  64'd1);
                chk("hold_data", 64'(res_data), 64'(held));
                chk("hold_done", 64'(done),     64'd0);
            end
            @(posedge clk);
            #1;
            res_rdy = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            seen  = done;
            if (poke && i == 2) begin
                chk("busy_during_job", 64'(busy), 64'd1);
                cfg_base   = 10'd300;
                cfg_nchunk = 10'd5;
                start      = 1'b1;
            end
        end
        start = 1'b0;
        if (!seen) fail("done_wait");
    endtask

    initial begin
        int v[$];
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        v = '{32, 32, 32};
        run_job(10'd5, 3, v, 0, 1'b0);
        v = '{-100, 30};
        run_job(10'd40, 2, v, 0, 1'b0);
        v = '{7, -3, 12, 900};
        run_job(10'd200, 4, v, 10, 1'b0);
        v.delete();
        run_job(10'd77, 0, v, 0, 1'b0);
        v = '{1, 2, 3, 4};
        run_job(10'd1022, 4, v, 0, 1'b0);
        v = '{5, 6, 7, 8, 9, 10};
        run_job(10'd500, 6, v, 0, 1'b1);

        // Abort a job in the middle of issuing.
        @(posedge clk);
        #1;
        cfg_base   = 10'd100;
        cfg_nchunk = 10'd8;
        start      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(ADDR_W'(100 + i));
            mac_src_q.push_back(rnd_val());
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        exp_addr_q.delete();
        mac_src_q.delete();
        @(negedge clk);
        chk_zero_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        v = '{-5, -6, 100};
        run_job(10'd9, 3, v, 0, 1'b0);

        for (int j = 0; j < 10; j++) begin
            int n;
            n = int'($urandom_range(1, 20));
            v.delete();
            for (int i = 0; i < n; i++) v.push_back(rnd_val());
            run_job(ADDR_W'($urandom), n, v, int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("queues_empty", 64'(exp_addr_q.size() + exp_res_q.size() + mac_src_q.size()
                                + pend_val_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
